// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with start/busy/done handshake, pipeline stall request and flush.
module riscv_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              kill,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t                     state, state_nxt;
  logic [2:0]                 op;
  logic signed [DATA_W-1:0]   opa, opb;
  logic [DATA_W-1:0]          opnd, mq, prev_result;
  logic [2*DATA_W-1:0]        acc;
  logic [CNT_W-1:0]           cnt;
  logic                       neg_res, neg_rem;

  logic                       is_div, sgn_a_op, sgn_b_op, sa, sb;
  logic                       div_zero, div_ovf, fast;
  logic [DATA_W-1:0]          mag_a, mag_b, fast_val, fin_val;
  logic [DATA_W:0]            add_sum, shifted, diff;
  logic [2*DATA_W-1:0]        acc_step, prod;
  logic [DATA_W-1:0]          mq_step, quo, rem;

  // Two's-complement negation when the recorded sign is negative
  function automatic logic [DATA_W-1:0] cond_neg_w(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand sign decode and divide fast-path detection (valid in PREP)
  assign is_div   = op[2];
  assign sgn_a_op = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign sgn_b_op = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign sa       = sgn_a_op & opa[DATA_W-1];
  assign sb       = sgn_b_op & opb[DATA_W-1];
  assign mag_a    = cond_neg_w($unsigned(opa), sa);
  assign mag_b    = cond_neg_w($unsigned(opb), sb);
  assign div_zero = is_div & ($unsigned(opb) == '0);
  assign div_ovf  = is_div & ~op[0] & ($unsigned(opa) == {1'b1, {(DATA_W-1){1'b0}}})
                  & ($unsigned(opb) == '1);
  assign fast     = div_zero | div_ovf;
  // Fast-path results are final: no sign fix-up afterwards
  assign fast_val = op[1] ? (div_zero ? $unsigned(opa) : '0)
                          : (div_zero ? '1 : $unsigned(opa));

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mq[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*DATA_W-1:DATA_W], mq[DATA_W-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      acc_step = diff[DATA_W] ? {shifted[DATA_W-1:0], acc[DATA_W-1:0]}
                              : {diff[DATA_W-1:0], acc[DATA_W-1:0]};
      mq_step  = {mq[DATA_W-2:0], ~diff[DATA_W]};
    end else begin
      acc_step = {add_sum, acc[DATA_W-1:1]};
      mq_step  = {1'b0, mq[DATA_W-1:1]};
    end
  end

  // Sign fix-up and result select on the final iteration's outputs, so the
  // result register is already valid in the done cycle
  always_comb begin
    prod = cond_neg_2w(acc_step, neg_res);
    quo  = cond_neg_w(mq_step, neg_res);
    rem  = cond_neg_w(acc_step[2*DATA_W-1:DATA_W], neg_rem);
    case (op)
      3'b000:                 fin_val = prod[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fin_val = quo;
      default:                fin_val = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !kill) state_nxt = PREP;
      PREP: if (kill)           state_nxt = IDLE;
            else if (fast)      state_nxt = FIN;
            else                state_nxt = CALC;
      CALC: if (kill)                        state_nxt = IDLE;
            else if (cnt == CNT_W'(1))       state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == FIN) & ~kill;
    stall = (start & ~kill & (state == IDLE)) | (busy & ~done);
  end

  // Control state: iteration counter and architectural result
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        PREP: begin
          cnt <= CNT_W'(DATA_W);
          if (fast && !kill) result <= fast_val;
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if ((cnt == CNT_W'(1)) && !kill) result <= fin_val;
        end
        // A flush in the done cycle withdraws the freshly written result
        FIN: if (kill) result <= prev_result;
        default: ;
      endcase
    end
  end

  // Datapath: operand capture, magnitudes, accumulator and quotient/multiplier
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start && !kill) begin
        op  <= Funct3;
        opa <= $signed(src_a);
        opb <= $signed(src_b);
      end
      PREP: begin
        prev_result <= result;
        acc         <= '0;
        neg_res     <= sa ^ sb;
        neg_rem     <= sa;
        if (is_div) begin
          mq   <= mag_a;
          opnd <= mag_b;
        end else begin
          mq   <= mag_b;
          opnd <= mag_a;
        end
      end
      CALC: begin
        acc <= acc_step;
        mq  <= mq_step;
      end
      default: ;
    endcase
  end

endmodule
